// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM encoding,
// flag bit positions and requester ids.
package alu_pkg;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int FLG_OVF   = 2;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_CARRY = 0;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    function automatic logic [2:0] pack_flags(input logic ovf, input logic zero, input logic carry);
        logic [2:0] f;
        f            = '0;
        f[FLG_OVF]   = ovf;
        f[FLG_ZERO]  = zero;
        f[FLG_CARRY] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; a tie goes to the requester that
// was not served last. Grant is one-hot, indexed by REQ_A/REQ_B.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       a_valid_i,
    input  logic       b_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (a_valid_i && b_valid_i) begin
            if (last_grant_i == REQ_B) grant_o[REQ_A] = 1'b1;
            else                       grant_o[REQ_B] = 1'b1;
        end else if (a_valid_i) begin
            grant_o[REQ_A] = 1'b1;
        end else if (b_valid_i) begin
            grant_o[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between requesters A and B: IDLE -> EXEC -> RESP.
// Optional per-requester op counters are enabled with ALU_ARB_PERF_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    // valid/ready: a transfer happens in any cycle where valid && ready; the
    // sender holds valid and payload stable until then.
    input  logic         a_req_valid,
    output logic         a_req_ready,
    input  logic [2:0]   a_opcode,
    input  logic [W-1:0] a_op1,
    input  logic [W-1:0] a_op2,
    output logic         a_rsp_valid,
    input  logic         a_rsp_ready,
    output logic [W-1:0] a_result,
    output logic [2:0]   a_flags,
    input  logic         b_req_valid,
    output logic         b_req_ready,
    input  logic [2:0]   b_opcode,
    input  logic [W-1:0] b_op1,
    input  logic [W-1:0] b_op2,
    output logic         b_rsp_valid,
    input  logic         b_rsp_ready,
    output logic [W-1:0] b_result,
    output logic [2:0]   b_flags,
    output logic [2:0]   alu_opcode,
    output logic [W-1:0] alu_r2,
    output logic [W-1:0] alu_r3,
    input  logic [W-1:0] alu_r0,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    input  logic         alu_carry,
    output state_e       dbg_state_o,
    output logic         busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]  a_op_count,
    output logic [15:0]  b_op_count
`endif
);

    state_e         state_q, state_d;
    logic           grant_id_q;
    logic           last_grant_q;
    logic [2:0]     alu_opcode_q;
    logic [W-1:0]   alu_r2_q, alu_r3_q;
    logic [W-1:0]   a_result_q, b_result_q;
    logic [2:0]     a_flags_q, b_flags_q;
    logic [1:0]     grant;
    logic           rsp_hs;

    rr_arb2 u_rr_arb2 (
        .a_valid_i    (a_req_valid),
        .b_valid_i    (b_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d     = state_q;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        rsp_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_req_ready = grant[REQ_A];
                    b_req_ready = grant[REQ_B];
                    state_d     = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                a_rsp_valid = (grant_id_q == REQ_A);
                b_rsp_valid = (grant_id_q == REQ_B);
                rsp_hs      = (a_rsp_valid && a_rsp_ready) || (b_rsp_valid && b_rsp_ready);
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= REQ_A;
            last_grant_q <= REQ_B;
            alu_opcode_q <= '0;
            alu_r2_q     <= '0;
            alu_r3_q     <= '0;
            a_result_q   <= '0;
            b_result_q   <= '0;
            a_flags_q    <= '0;
            b_flags_q    <= '0;
        end else begin
            state_q <= state_d;
            // Operands are only ever loaded from registers, so alu_* never sees req_* combinationally.
            if (state_q == IDLE && (|grant)) begin
                grant_id_q   <= grant[REQ_B];
                alu_opcode_q <= grant[REQ_A] ? a_opcode : b_opcode;
                alu_r2_q     <= grant[REQ_A] ? a_op1    : b_op1;
                alu_r3_q     <= grant[REQ_A] ? a_op2    : b_op2;
            end
            if (state_q == EXEC) begin
                if (grant_id_q == REQ_A) begin
                    a_result_q <= alu_r0;
                    a_flags_q  <= pack_flags(alu_overflow, alu_zero, alu_carry);
                end else begin
                    b_result_q <= alu_r0;
                    b_flags_q  <= pack_flags(alu_overflow, alu_zero, alu_carry);
                end
            end
            if (rsp_hs) last_grant_q <= grant_id_q;
        end
    end

    assign alu_opcode  = alu_opcode_q;
    assign alu_r2      = alu_r2_q;
    assign alu_r3      = alu_r3_q;
    assign a_result    = a_result_q;
    assign a_flags     = a_flags_q;
    assign b_result    = b_result_q;
    assign b_flags     = b_flags_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] a_op_cnt_q, b_op_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_op_cnt_q <= '0;
            b_op_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (grant_id_q == REQ_A && a_op_cnt_q != 16'hFFFF) a_op_cnt_q <= a_op_cnt_q + 16'd1;
            if (grant_id_q == REQ_B && b_op_cnt_q != 16'hFFFF) b_op_cnt_q <= b_op_cnt_q + 16'd1;
        end
    end

    assign a_op_count = a_op_cnt_q;
    assign b_op_count = b_op_cnt_q;
`endif

`ifndef SYNTHESIS
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        a_req_valid && !a_req_ready |=> a_req_valid && $stable({a_opcode, a_op1, a_op2}));
    b_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        b_req_valid && !b_req_ready |=> b_req_valid && $stable({b_opcode, b_op1, b_op2}));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; counter checks run
// when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [2:0]   a_opcode, a_flags;
    logic [W-1:0] a_op1, a_op2, a_result;
    logic         b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [2:0]   b_opcode, b_flags;
    logic [W-1:0] b_op1, b_op2, b_result;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_r2, alu_r3, alu_r0;
    logic         alu_overflow, alu_zero, alu_carry;
    logic [1:0]   dbg_state;
    logic         busy;
`ifdef ALU_ARB_PERF_EN
    logic [15:0]  a_op_count, b_op_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_a_res, exp_b_res;
    logic [2:0]   exp_a_flg, exp_b_flg;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_opcode     (a_opcode),
        .a_op1        (a_op1),
        .a_op2        (a_op2),
        .a_rsp_valid  (a_rsp_valid),
        .a_rsp_ready  (a_rsp_ready),
        .a_result     (a_result),
        .a_flags      (a_flags),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_opcode     (b_opcode),
        .b_op1        (b_op1),
        .b_op2        (b_op2),
        .b_rsp_valid  (b_rsp_valid),
        .b_rsp_ready  (b_rsp_ready),
        .b_result     (b_result),
        .b_flags      (b_flags),
        .alu_opcode   (alu_opcode),
        .alu_r2       (alu_r2),
        .alu_r3       (alu_r3),
        .alu_r0       (alu_r0),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .dbg_state_o  (dbg_state),
        .busy         (busy)
`ifdef ALU_ARB_PERF_EN
        ,
        .a_op_count   (a_op_count),
        .b_op_count   (b_op_count)
`endif
    );

    // Behavioural ALU: carry is the adder carry-out (SUB = r2 + ~r3 + 1),
    // logic ops/MOV/SLT report carry=0 and overflow=0.
    always_comb begin
        logic [W:0] sum;
        sum          = '0;
        alu_r0       = '0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        case (alu_opcode)
            3'b000: alu_r0 = alu_r2;
            3'b001: alu_r0 = ~alu_r2;
            3'b010: begin
                sum          = {1'b0, alu_r2} + {1'b0, alu_r3};
                alu_r0       = sum[W-1:0];
                alu_carry    = sum[W];
                alu_overflow = (alu_r2[W-1] == alu_r3[W-1]) && (sum[W-1] != alu_r2[W-1]);
            end
            3'b011: alu_r0 = ~(alu_r2 | alu_r3);
            3'b100: begin
                sum          = {1'b0, alu_r2} + {1'b0, ~alu_r3} + {{W{1'b0}}, 1'b1};
                alu_r0       = sum[W-1:0];
                alu_carry    = sum[W];
                alu_overflow = (alu_r2[W-1] != alu_r3[W-1]) && (sum[W-1] != alu_r2[W-1]);
            end
            3'b101: alu_r0 = ~(alu_r2 & alu_r3);
            3'b110: alu_r0 = alu_r2 & alu_r3;
            default: alu_r0 = {{(W-1){1'b0}}, ($signed(alu_r2) < $signed(alu_r3))};
        endcase
        alu_zero = (alu_r0 == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        a_req_valid = 0; a_opcode = '0; a_op1 = '0; a_op2 = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_opcode = '0; b_op1 = '0; b_op2 = '0; b_rsp_ready = 0;
        exp_a_res = '0; exp_b_res = '0; exp_a_flg = '0; exp_b_flg = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drive_req(input logic who, input logic [2:0] op, input logic [W-1:0] op1,
                             input logic [W-1:0] op2);
        if (who == 1'b0) begin
            a_req_valid = 1'b1; a_opcode = op; a_op1 = op1; a_op2 = op2;
        end else begin
            b_req_valid = 1'b1; b_opcode = op; b_op1 = op1; b_op2 = op2;
        end
    endtask

    // Single operation from an idle arbiter with only one requester active.
    task automatic run_op(input logic who, input logic [2:0] op, input logic [W-1:0] op1,
                          input logic [W-1:0] op2, input logic [W-1:0] exp_r, input logic [2:0] exp_f);
        drive_req(who, op, op1, op2);
        #1;
        check("req_ready_T", who ? b_req_ready : a_req_ready, 1);
        check("other_req_ready_T", who ? a_req_ready : b_req_ready, 0);
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        #1;
        check("busy_exec", busy, 1);
        check("alu_opcode_exec", alu_opcode, op);
        check("alu_r2_exec", alu_r2, op1);
        check("alu_r3_exec", alu_r3, op2);
        check("rsp_valid_T1", who ? b_rsp_valid : a_rsp_valid, 0);
        tick();
        check("rsp_valid_T2", who ? b_rsp_valid : a_rsp_valid, 1);
        check("other_rsp_valid_T2", who ? a_rsp_valid : b_rsp_valid, 0);
        check("result", who ? b_result : a_result, exp_r);
        check("flags", who ? b_flags : a_flags, exp_f);
        check("other_result_kept", who ? a_result : b_result, who ? exp_a_res : exp_b_res);
        check("other_flags_kept", who ? a_flags : b_flags, who ? exp_a_flg : exp_b_flg);
        if (who) begin b_rsp_ready = 1'b1; exp_b_res = exp_r; exp_b_flg = exp_f; end
        else     begin a_rsp_ready = 1'b1; exp_a_res = exp_r; exp_a_flg = exp_f; end
        tick();
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        #1;
        check("busy_after_hs", busy, 0);
        check("rsp_valid_after_hs", who ? b_rsp_valid : a_rsp_valid, 0);
    endtask

    typedef struct {
        logic         who;
        logic [2:0]   op;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [W-1:0] res;
        logic [2:0]   flg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // {who, opcode, op1, op2, result, {ovf,zero,carry}}
        vecs[0] = '{1'b0, 3'b010, 32'd5,        32'd7,        32'd12,       3'b000};
        vecs[1] = '{1'b1, 3'b100, 32'd3,        32'd3,        32'd0,        3'b011};
        vecs[2] = '{1'b0, 3'b011, 32'd0,        32'd0,        32'hFFFFFFFF, 3'b000};
        vecs[3] = '{1'b1, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        3'b010};
        vecs[4] = '{1'b0, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        3'b011};
        vecs[5] = '{1'b1, 3'b010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 3'b100};
        vecs[6] = '{1'b0, 3'b000, 32'hDEADBEEF, 32'd9,        32'hDEADBEEF, 3'b000};
        vecs[7] = '{1'b1, 3'b111, 32'd1,        32'hFFFFFFFF, 32'd0,        3'b010};

        // Reset state, sampled while reset is held
        rst_n = 1'b0;
        a_req_valid = 0; a_opcode = '0; a_op1 = '0; a_op2 = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_opcode = '0; b_op1 = '0; b_op2 = '0; b_rsp_ready = 0;
        tick();
        check("rst_state", dbg_state, 0);
        check("rst_busy", busy, 0);
        check("rst_a_req_ready", a_req_ready, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_r2", alu_r2, 0);
        check("rst_a_result", a_result, 0);
        check("rst_b_flags", b_flags, 0);
`ifdef ALU_ARB_PERF_EN
        check("rst_a_op_count", a_op_count, 0);
        check("rst_b_op_count", b_op_count, 0);
`endif
        reset_dut();

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].who, vecs[i].op, vecs[i].op1, vecs[i].op2, vecs[i].res, vecs[i].flg);
        check("alu_hold_idle", alu_opcode, 3'b111);

        // Tie from reset: A first, then B, then A again
        reset_dut();
        drive_req(1'b0, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00);
        drive_req(1'b1, 3'b111, 32'hFFFFFFFF, 32'd1);
        #1;
        check("tie0_a_ready", a_req_ready, 1);
        check("tie0_b_ready", b_req_ready, 0);
        tick();
        a_req_valid = 1'b0;
        #1;
        check("tie0_b_wait_exec", b_req_ready, 0);
        tick();
        check("tie0_a_rsp_valid", a_rsp_valid, 1);
        check("tie0_a_result", a_result, 32'hF000F000);
        check("tie0_b_wait_resp", b_req_ready, 0);
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        #1;
        check("tie0_b_ready", b_req_ready, 1);
        tick();
        b_req_valid = 1'b0;
        tick();
        check("tie0_b_rsp_valid", b_rsp_valid, 1);
        check("tie0_b_result", b_result, 32'd1);
        check("tie0_a_result_kept", a_result, 32'hF000F000);
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;

        // Tie again (last_grant=B) with a stalled A response
        drive_req(1'b0, 3'b100, 32'h80000000, 32'd1);
        drive_req(1'b1, 3'b010, 32'd2, 32'd3);
        #1;
        check("tie1_a_ready", a_req_ready, 1);
        check("tie1_b_ready", b_req_ready, 0);
        tick();
        a_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_a_rsp_valid", a_rsp_valid, 1);
            check("stall_a_result", a_result, 32'h7FFFFFFF);
            check("stall_a_flags", a_flags, 3'b101);
            check("stall_b_req_ready", b_req_ready, 0);
            tick();
        end
        a_rsp_ready = 1'b1;
        #1;
        check("stall_b_req_ready_hs", b_req_ready, 0);
        tick();
        a_rsp_ready = 1'b0;
        #1;
        check("stall_b_granted", b_req_ready, 1);
        check("stall_a_rsp_dropped", a_rsp_valid, 0);
        tick();
        b_req_valid = 1'b0;
        tick();
        check("stall_b_result", b_result, 32'd5);
        check("stall_b_flags", b_flags, 3'b000);
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;

        // Async reset during EXEC discards the operation
        drive_req(1'b0, 3'b000, 32'h1234, 32'd0);
        tick();
        a_req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_alu_r2", alu_r2, 0);
        tick();
        rst_n = 1'b1;
        exp_a_res = '0; exp_b_res = '0; exp_a_flg = '0; exp_b_flg = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_a_rsp_valid", a_rsp_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        run_op(1'b0, 3'b001, 32'd0, 32'd0, 32'hFFFFFFFF, 3'b000);

`ifdef ALU_ARB_PERF_EN
        reset_dut();
        run_op(1'b0, 3'b010, 32'd1, 32'd1, 32'd2, 3'b000);
        run_op(1'b1, 3'b010, 32'd2, 32'd2, 32'd4, 3'b000);
        run_op(1'b0, 3'b010, 32'd3, 32'd3, 32'd6, 3'b000);
        run_op(1'b1, 3'b010, 32'd4, 32'd4, 32'd8, 3'b000);
        run_op(1'b0, 3'b010, 32'd5, 32'd5, 32'd10, 3'b000);
        check("perf_a_op_count", a_op_count, 3);
        check("perf_b_op_count", b_op_count, 2);
        force dut.a_op_cnt_q = 16'hFFFF;
        #1;
        release dut.a_op_cnt_q;
        run_op(1'b0, 3'b110, 32'hFF, 32'h0F, 32'h0F, 3'b000);
        check("perf_a_saturate", a_op_count, 16'hFFFF);
        check("perf_b_unchanged", b_op_count, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin scheduler that shares one W-bit ALU (3-bit opcode; result plus overflow/zero/carry flags) between requesters A and B. It accepts an operation over a valid/ready request channel and drives the external ALU from registered operands. It captures the result and flags, then returns them over a valid/ready response channel to the requester that was granted. It sits between two issuing units (e.g. core and DMA/test sequencer) and the shared ALU instance.

Parameters:
W, 32, operand/result width; must match the attached ALU

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req_valid  in  1  requester A has an operation
a_req_ready  out  1  A's request accepted this cycle
a_opcode  in  3  A opcode (000 MOV, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 AND, 111 SLT)
a_op1  in  W  A first operand (ALU R2)
a_op2  in  W  A second operand (ALU R3)
a_rsp_valid  out  1  A response available
a_rsp_ready  in  1  A consumes response
a_result  out  W  A result
a_flags  out  3  {overflow, zero, carry} for A
b_*  (same nine signals for requester B)
alu_opcode  out  3  to ALU opcode
alu_r2  out  W  to ALU first operand
alu_r3  out  W  to ALU second operand
alu_r0  in  W  ALU result
alu_overflow  in  1  ALU overflow flag
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry flag
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all req_ready/rsp_valid=0; result/flags/alu_* registers=0; last_grant=B, so A wins the first tie; busy=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If either req_valid is high, grant it. If both are high, grant the one not equal to last_grant.
  - Assert only the granted req_ready, combinationally, in that cycle.
  - Latch opcode/op1/op2 into alu_* registers and the grant id. Go to EXEC.
  - Stay in IDLE when no request is pending.
- EXEC: alu_* are stable for exactly one cycle. At the clock edge, capture alu_r0 and {alu_overflow, alu_zero, alu_carry} into that requester's result/flags registers. Go to RESP.
- RESP:
  - Granted rsp_valid=1; result/flags stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: drop rsp_valid, set last_grant=grant id, go to IDLE.
  - Any number of stall cycles is legal.
- Both req_ready outputs are 0 outside IDLE. A request that arrives during EXEC/RESP waits; the arbiter never drops it.
- Requester protocol: once raised, req_valid and payload stay stable until req_ready. Protocol violations are undefined; an assertion is added in simulation.
- Latency: request accepted at cycle T, rsp_valid at T+2. Minimum 3 cycles per operation; no overlap.
- The non-granted requester's result/flags keep their previous values.
- Flags are forwarded from the ALU unmodified, with no reinterpretation per opcode.
- Async reset mid-EXEC or mid-RESP: the in-flight operation is discarded and no response is issued. After release, state returns to IDLE.
- alu_* outputs hold the last operation in IDLE. There is no combinational path from req_* to alu_*.

Optional Feature:
ALU_ARB_PERF_EN:
- Defined: adds outputs a_op_count[15:0] and b_op_count[15:0].
  - Each counter increments on that requester's response handshake and saturates at 16'hFFFF.
  - Both counters reset to 0 on rst_n.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_MOV..OP_SLT;
  - state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - flag bit indices FLG_OVF=2, FLG_ZERO=1, FLG_CARRY=0;
  - requester ids REQ_A=0, REQ_B=1.
- One sub-module, rr_arb2: combinational two-way round-robin grant from {a_valid, b_valid, last_grant}, returning a one-hot grant.

Test Plan:
- Reset, then A: ADD op1=5, op2=7 -> a_req_ready at T, a_rsp_valid at T+2, a_result=12, a_flags=3'b000; b_rsp_valid stays 0.
- B: SUB 3,3 -> b_result=0, b_flags=3'b011 (zero=1, carry=1).
- Both valid from reset with A=AND 0xF0F0F0F0,0xFF00FF00 and B=SLT 0xFFFFFFFF,1:
  - A is served first with result 0xF000F000;
  - B is served next with result 1.
  - Then both valid again -> A is granted (last_grant=B).
- A SUB 0x80000000,1 with a_rsp_ready held 0 for 5 cycles:
  - a_rsp_valid stays high, a_result=0x7FFFFFFF and overflow=1 stay stable;
  - b_req_ready stays 0 despite b_req_valid=1;
  - B is granted the cycle after the A handshake.
- Pulse rst_n low during EXEC of A MOV 0x1234 -> no a_rsp_valid after release; busy=0; next A NOT 0 yields 0xFFFFFFFF with flags 3'b000.
- With ALU_ARB_PERF_EN: 3 A ops and 2 B ops -> a_op_count=3, b_op_count=2. Preload a_op_count to 0xFFFF via force and run one more A op -> a_op_count stays 0xFFFF.
